plic_core_pipe: RTL and testbench

Next-generation PLIC core for many-source, many-target systems. It adds:
- a per-source gateway with a pending counter;
- an optionally registered priority-select tree per target;
- atomic claim arbitration across targets;
- explicit claim response and complete-ID ports, so software-visible claim/complete semantics are exact.

It sits between the bus register file (ie/priority/threshold/claim/complete registers) and the hart interrupt inputs.

---
 rtl/plic_core_pipe.sv | 260 ++++++++++++++++++++++++++
 tb/tb_plic_core_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_core_pipe.sv
// plic_core_pipe -- interrupt controller core: per-source gateways with an
// edge-request pending counter, a per-target priority-select tree with
// optional register stages, atomic cross-target claim arbitration and
// explicit claim-response / complete-ID handling.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   src, el        raw requests and per-source mode (1 = edge, 0 = level)
//   ip             registered pending bit per source
//   ie             per-target, per-source enable
//   ipriority      per-source priority (0 = never interrupts)
//   threshold      per-target threshold
//   ireq, id       per-target request and best candidate ID (0 = none)
//   claim          per-target claim strobe; claim_id answers one cycle later
//   complete       per-target complete strobe with complete_id
//
// Build option:
//   PLIC_SRC_SYNC_EN  when defined, src passes through a 2-flop
//                     synchronizer (src-to-ip latency 3 cycles); otherwise
//                     src is only registered for edge detection (latency 1).
module plic_core_pipe #(
  parameter int SOURCES           = 32,
  parameter int TARGETS           = 2,
  parameter int PRIORITIES        = 8,
  parameter int MAX_PENDING_COUNT = 0,
  parameter int PIPE_STAGES       = 1,
  parameter int SOURCES_BITS      = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS     = $clog2(PRIORITIES)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [SOURCES-1:0]                        src,
  input  logic [SOURCES-1:0]                        el,
  output logic [SOURCES-1:0]                        ip,
  input  logic [TARGETS-1:0][SOURCES-1:0]           ie,
  input  logic [SOURCES-1:0][PRIORITY_BITS-1:0]     ipriority,
  input  logic [TARGETS-1:0][PRIORITY_BITS-1:0]     threshold,
  output logic [TARGETS-1:0]                        ireq,
  output logic [TARGETS-1:0][SOURCES_BITS-1:0]      id,
  input  logic [TARGETS-1:0]                        claim,
  output logic [TARGETS-1:0][SOURCES_BITS-1:0]      claim_id,
  input  logic [TARGETS-1:0]                        complete,
  input  logic [TARGETS-1:0][SOURCES_BITS-1:0]      complete_id
);

  localparam int SB      = SOURCES_BITS;
  localparam int PB      = PRIORITY_BITS;
  localparam int NW      = PB + SB;
  localparam int LEVELS  = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int NPOW    = 1 << LEVELS;
  localparam int THR_IDX = (PIPE_STAGES > 0) ? PIPE_STAGES - 1 : 0;
  localparam int CNT_W   = (MAX_PENDING_COUNT > 0) ? $clog2(MAX_PENDING_COUNT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);

  // The last PIPE_STAGES levels of the tree (closest to the root) are
  // registered; level 0 (the leaves) is always combinational.
  function automatic logic is_reg(input int lvl);
    return (lvl >= 1) && (lvl > LEVELS - PIPE_STAGES);
  endfunction

  // ---------------------------------------------------------------------
  // Input capture. These flops carry no reset on purpose: they keep
  // tracking src through reset, so a level held high across reset does
  // not look like a fresh rising edge afterwards.
  // ---------------------------------------------------------------------
  logic [SOURCES-1:0] w_src;
  logic [SOURCES-1:0] r_src_prev;
  logic [SOURCES-1:0] w_edge;

`ifdef PLIC_SRC_SYNC_EN
  logic [SOURCES-1:0] r_sync1;
  logic [SOURCES-1:0] r_sync2;

  always_ff @(posedge clk) begin
    r_sync1 <= src;
    r_sync2 <= r_sync1;
  end

  assign w_src = r_sync2;
`else
  assign w_src = src;
`endif

  always_ff @(posedge clk) begin
    r_src_prev <= w_src;
  end

  assign w_edge = w_src & ~r_src_prev;

  // ---------------------------------------------------------------------
  // Claim arbitration and complete decode
  // ---------------------------------------------------------------------
  logic [SOURCES-1:0]              r_ip;
  logic [SOURCES-1:0]              r_insvc;
  logic [CNT_W-1:0]                r_cnt [SOURCES];
  logic [TARGETS-1:0][SB-1:0]      r_id;
  logic [TARGETS-1:0]              r_ireq;
  logic [TARGETS-1:0][SB-1:0]      r_claim_id;

  logic [SOURCES-1:0]              w_grant;
  logic [SOURCES-1:0]              w_done;
  logic [TARGETS-1:0]              w_claim_ok;

  // Targets are scanned in index order, so when several claim the same ID
  // in one cycle the lowest index takes it and the rest see it as taken.
  always_comb begin
    w_grant    = '0;
    w_done     = '0;
    w_claim_ok = '0;
    for (int t = 0; t < TARGETS; t++) begin
      for (int s = 0; s < SOURCES; s++) begin
        if (claim[t] && (r_id[t] == SB'(s + 1)) && r_ip[s] && !w_grant[s]) begin
          w_grant[s]    = 1'b1;
          w_claim_ok[t] = 1'b1;
        end
        if (complete[t] && (complete_id[t] == SB'(s + 1)) && r_insvc[s]) begin
          w_done[s] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Gateways. ip and in-service are never both set, so a grant and a
  // complete can never hit the same source in the same cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ip    <= '0;
      r_insvc <= '0;
      for (int s = 0; s < SOURCES; s++) begin
        r_cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SOURCES; s++) begin
        if (w_grant[s]) begin
          r_ip[s]    <= 1'b0;
          r_insvc[s] <= 1'b1;
          if (el[s] && w_edge[s] && (r_cnt[s] != CNT_MAX)) begin
            r_cnt[s] <= r_cnt[s] + 1'b1;
          end
        end else if (w_done[s]) begin
          r_insvc[s] <= 1'b0;
          if (el[s]) begin
            // An edge landing with the complete is queued and consumed at
            // once: ip re-arms and the counter is left alone.
            if (w_edge[s]) begin
              r_ip[s] <= 1'b1;
            end else if (r_cnt[s] != '0) begin
              r_ip[s]  <= 1'b1;
              r_cnt[s] <= r_cnt[s] - 1'b1;
            end
          end
        end else if (!r_ip[s] && !r_insvc[s]) begin
          if (el[s] ? w_edge[s] : w_src[s]) begin
            r_ip[s] <= 1'b1;
          end
        end else if (el[s] && w_edge[s] && (r_cnt[s] != CNT_MAX)) begin
          r_cnt[s] <= r_cnt[s] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Priority-select tree, one per target. Node = {priority, id}; a
  // non-candidate leaf is all zeros. The right (higher-ID) child wins only
  // on strictly greater priority, so ties go to the lowest ID.
  // ---------------------------------------------------------------------
  logic [NW-1:0] w_node [TARGETS][LEVELS+1][NPOW];
  logic [NW-1:0] r_node [TARGETS][LEVELS+1][NPOW];
  logic [PB-1:0] r_thr  [TARGETS][PIPE_STAGES+1];
  logic [NW-1:0] w_root [TARGETS];
  logic [PB-1:0] w_thr_eff [TARGETS];

  always_comb begin
    logic [NW-1:0] v_a;
    logic [NW-1:0] v_b;
    v_a = '0;
    v_b = '0;
    for (int t = 0; t < TARGETS; t++) begin
      for (int l = 0; l <= LEVELS; l++) begin
        for (int n = 0; n < NPOW; n++) begin
          w_node[t][l][n] = '0;
        end
      end
      for (int s = 0; s < SOURCES; s++) begin
        if (r_ip[s] && ie[t][s] && (ipriority[s] != '0)) begin
          w_node[t][0][s] = {ipriority[s], SB'(s + 1)};
        end
      end
      for (int l = 1; l <= LEVELS; l++) begin
        for (int n = 0; n < (NPOW >> l); n++) begin
          v_a = is_reg(l - 1) ? r_node[t][l-1][2*n]   : w_node[t][l-1][2*n];
          v_b = is_reg(l - 1) ? r_node[t][l-1][2*n+1] : w_node[t][l-1][2*n+1];
          w_node[t][l][n] = (v_b[NW-1 -: PB] > v_a[NW-1 -: PB]) ? v_b : v_a;
        end
      end
      w_root[t]    = is_reg(LEVELS) ? r_node[t][LEVELS][0] : w_node[t][LEVELS][0];
      // Threshold is delayed by the same number of stages as the tree so
      // every input reaches id/ireq with the same latency.
      w_thr_eff[t] = (PIPE_STAGES == 0) ? threshold[t] : r_thr[t][THR_IDX];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < TARGETS; t++) begin
        for (int l = 0; l <= LEVELS; l++) begin
          for (int n = 0; n < NPOW; n++) begin
            r_node[t][l][n] <= '0;
          end
        end
        for (int k = 0; k <= PIPE_STAGES; k++) begin
          r_thr[t][k] <= '0;
        end
      end
    end else begin
      for (int t = 0; t < TARGETS; t++) begin
        for (int l = 1; l <= LEVELS; l++) begin
          if (is_reg(l)) begin
            for (int n = 0; n < (NPOW >> l); n++) begin
              r_node[t][l][n] <= w_node[t][l][n];
            end
          end
        end
        r_thr[t][0] <= threshold[t];
        for (int k = 1; k < PIPE_STAGES; k++) begin
          r_thr[t][k] <= r_thr[t][k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output registers: id shows the winner even when it is at or below the
  // threshold; only ireq is gated by the threshold.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id       <= '0;
      r_ireq     <= '0;
      r_claim_id <= '0;
    end else begin
      for (int t = 0; t < TARGETS; t++) begin
        r_id[t]   <= w_root[t][SB-1:0];
        r_ireq[t] <= (w_root[t][SB-1:0] != '0) && (w_root[t][NW-1 -: PB] > w_thr_eff[t]);
        if (claim[t]) begin
          r_claim_id[t] <= w_claim_ok[t] ? r_id[t] : '0;
        end
      end
    end
  end

  assign ip       = r_ip;
  assign ireq     = r_ireq;
  assign id       = r_id;
  assign claim_id = r_claim_id;

endmodule

// File: tb/tb_plic_core_pipe.sv
module tb_plic_core_pipe;
  localparam int S  = 32;
  localparam int T  = 2;
  localparam int PB = 3;
  localparam int SB = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [S-1:0]          src, el, ip;
  logic [T-1:0][S-1:0]   ie;
  logic [S-1:0][PB-1:0]  ipriority;
  logic [T-1:0][PB-1:0]  threshold;
  logic [T-1:0]          ireq, claim, complete;
  logic [T-1:0][SB-1:0]  id, claim_id, complete_id;

  plic_core_pipe #(
    .SOURCES(S), .TARGETS(T), .PRIORITIES(8),
    .MAX_PENDING_COUNT(2), .PIPE_STAGES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .el(el), .ip(ip), .ie(ie),
    .ipriority(ipriority), .threshold(threshold), .ireq(ireq), .id(id),
    .claim(claim), .claim_id(claim_id), .complete(complete),
    .complete_id(complete_id)
  );

  always #5 clk = ~clk;

  // kind: 0 ip bit, 1 id[t], 2 ireq[t], 3 claim_id[t], 4 whole ip vector
  typedef struct {
    string name;
    int    kind;
    int    idx;
    int    exp;
  } chk_t;

  chk_t q_prb[$];
  chk_t q_clm[$];
  int n_vec = 0;
  int n_err = 0;
  logic [T-1:0] claim_seen;

  always @(posedge clk) claim_seen <= claim;

  always @(negedge clk) begin
    chk_t c;
    int act;
    for (int t = 0; t < T; t++) begin
      if (claim_seen[t]) begin
        n_vec++;
        if (q_clm.size() == 0) begin
          n_err++;
          $display("FAIL claim_unexpected: target %0d claim_id=%0d, no response expected", t, claim_id[t]);
        end else begin
          c = q_clm.pop_front();
          act = int'(claim_id[t]);
          if (c.idx != t || act != c.exp) begin
            n_err++;
            $display("FAIL %s: target %0d claim_id=%0d, expected target %0d value %0d", c.name, t, act, c.idx, c.exp);
          end
        end
      end
    end
    while (q_prb.size() > 0) begin
      c = q_prb.pop_front();
      case (c.kind)
        0:       act = int'(ip[c.idx]);
        1:       act = int'(id[c.idx]);
        2:       act = int'(ireq[c.idx]);
        3:       act = int'(claim_id[c.idx]);
        default: act = int'(ip);
      endcase
      n_vec++;
      if (act != c.exp) begin
        n_err++;
        $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", c.name, act, act, c.exp, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input int kind, input int idx, input int exp);
    chk_t c;
    c.name = name; c.kind = kind; c.idx = idx; c.exp = exp;
    q_prb.push_back(c);
  endtask

  task automatic do_claim(input string name, input int t, input int exp);
    chk_t c;
    c.name = name; c.kind = 3; c.idx = t; c.exp = exp;
    q_clm.push_back(c);
    claim[t] = 1'b1;
    tick();
    claim[t] = 1'b0;
  endtask

  task automatic do_complete(input int t, input int idv);
    complete[t]    = 1'b1;
    complete_id[t] = SB'(idv);
    tick();
    complete[t]    = 1'b0;
    complete_id[t] = '0;
  endtask

  task automatic pulse(input int s);
    src[s] = 1'b1;
    tick();
    src[s] = 1'b0;
    tick();
  endtask

  initial begin
    chk_t c2;
    rst_n = 1'b0; src = '0; el = '0; ie = '0; ipriority = '0; threshold = '0;
    claim = '0; complete = '0; complete_id = '0;
    ticks(3);
    rst_n = 1'b1;
    tick();
    chk("rst_ip", 4, 0, 0);
    chk("rst_id0", 1, 0, 0);
    chk("rst_ireq0", 2, 0, 0);
    chk("rst_claim_id0", 3, 0, 0);

    // Level source 4, priority 3, threshold 1
    ipriority[4] = 3'd3; ie[0][4] = 1'b1; threshold[0] = 3'd1; src[4] = 1'b1;
    tick();
    chk("lvl_ip4_set", 0, 4, 1);
    chk("lvl_id0_in_pipe", 1, 0, 0);
    ticks(2);
    chk("lvl_id0", 1, 0, 5);
    chk("lvl_ireq0", 2, 0, 1);
    chk("lvl_id1_disabled", 1, 1, 0);
    do_claim("lvl_claim", 0, 5);
    chk("lvl_ip4_claimed", 0, 4, 0);
    ticks(2);
    chk("lvl_claim_id_hold", 3, 0, 5);
    do_complete(0, 5);
    tick();
    chk("lvl_ip4_reassert", 0, 4, 1);

    // Equal priorities on sources 2 and 7, then priority and threshold changes
    ie[0] = '0; ie[0][2] = 1'b1; ie[0][7] = 1'b1;
    ipriority[2] = 3'd5; ipriority[7] = 3'd5; src[2] = 1'b1; src[7] = 1'b1;
    ticks(3);
    chk("tie_low_id", 1, 0, 3);
    chk("tie_ireq", 2, 0, 1);
    ipriority[7] = 3'd6;
    tick();
    chk("pri_latency", 1, 0, 3);
    tick();
    chk("pri_raise", 1, 0, 8);
    threshold[0] = 3'd6;
    tick();
    chk("thr_latency", 2, 0, 1);
    tick();
    chk("thr_equal_ireq", 2, 0, 0);
    chk("thr_equal_id", 1, 0, 8);
    threshold[0] = 3'd5;
    ticks(2);
    chk("thr_below_ireq", 2, 0, 1);

    // Two targets claiming source 3 together, then a stale claim
    ie = '0; ie[0][3] = 1'b1; ie[1][3] = 1'b1;
    ipriority[3] = 3'd2; src[3] = 1'b1; threshold = '0;
    ticks(3);
    chk("dual_id0", 1, 0, 4);
    chk("dual_id1", 1, 1, 4);
    c2.name = "dual_claim_t0"; c2.kind = 3; c2.idx = 0; c2.exp = 4; q_clm.push_back(c2);
    c2.name = "dual_claim_t1"; c2.kind = 3; c2.idx = 1; c2.exp = 0; q_clm.push_back(c2);
    claim = 2'b11;
    tick();
    claim = 2'b00;
    do_claim("stale_claim", 0, 0);
    chk("dual_ip3_clr", 0, 3, 0);
    src[3] = 1'b0;
    do_complete(1, 4);
    ticks(2);
    chk("dual_ip3_no_reassert", 0, 3, 0);

    // Edge source 0 with pending counter (saturates at 2)
    ie = '0; ie[0][0] = 1'b1; el[0] = 1'b1; ipriority[0] = 3'd4;
    pulse(0);
    chk("edge_ip0_set", 0, 0, 1);
    tick();
    chk("edge_id0", 1, 0, 1);
    do_claim("edge_claim0", 0, 1);
    for (int k = 0; k < 4; k++) pulse(0);
    chk("edge_ip0_insvc", 0, 0, 0);
    do_complete(0, 1);
    chk("edge_requeue1", 0, 0, 1);
    ticks(2);
    do_claim("edge_claim1", 0, 1);
    do_complete(0, 1);
    ticks(2);
    do_claim("edge_claim2", 0, 1);
    do_complete(0, 1);
    ticks(2);
    chk("edge_ip0_drained", 0, 0, 0);
    chk("edge_id0_none", 1, 0, 0);
    do_claim("edge_claim3", 0, 0);

    // Edge in the same cycle as complete: re-arms ip, counter unchanged
    pulse(0);
    tick();
    do_claim("edge_cc_claim", 0, 1);
    src[0] = 1'b1; complete[0] = 1'b1; complete_id[0] = SB'(1);
    tick();
    src[0] = 1'b0; complete[0] = 1'b0; complete_id[0] = '0;
    chk("edge_cc_ip0", 0, 0, 1);
    ticks(2);
    do_claim("edge_cc_claim2", 0, 1);
    do_complete(0, 1);
    tick();
    chk("edge_cc_no_queue", 0, 0, 0);

    // Reset while source 0 is in service with one queued edge
    pulse(0);
    tick();
    do_claim("rst_pre_claim", 0, 1);
    pulse(0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ip", 4, 0, 0);
    chk("mid_rst_id0", 1, 0, 0);
    chk("mid_rst_claim_id0", 3, 0, 0);
    tick();
    chk("post_rst_levels", 4, 0, 32'h94);
    ticks(3);
    chk("post_rst_ip0_quiet", 0, 0, 0);
    pulse(0);
    chk("post_rst_new_edge", 0, 0, 1);

    ticks(2);
    n_vec++;
    if (q_prb.size() != 0 || q_clm.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expectations: probes=%0d claims=%0d, expected 0 and 0", q_prb.size(), q_clm.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
